// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha keystream consumer blocks.
package chacha_pkg;

  localparam int CHACHA_BLK_W         = 512;
  localparam int DEFAULT_RETRY_CYCLES = 64;

  typedef enum logic {
    R_IDLE,
    R_WAIT
  } req_state_e;

endpackage

// File: rtl/chacha_ks_fifo2.sv
// Two-entry keystream block FIFO; slot 0 is always the head.
module chacha_ks_fifo2
  import chacha_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [CHACHA_BLK_W-1:0] data_i,
  output logic [CHACHA_BLK_W-1:0] head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [1:0]              count_o
);

  logic [CHACHA_BLK_W-1:0] slot0_q, slot0_d;
  logic [CHACHA_BLK_W-1:0] slot1_q, slot1_d;
  logic [1:0]              count_q, count_d;
  logic                    pushOk;
  logic                    popOk;

  assign popOk  = pop_i && (count_q != 2'd0);
  assign pushOk = push_i && ((count_q != 2'd2) || popOk);

  // Clear wins over everything; a simultaneous push and pop keeps occupancy.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else if (pushOk && popOk) begin
      if (count_q == 2'd2) begin
        slot0_d = slot1_q;
        slot1_d = data_i;
      end else begin
        slot0_d = data_i;
      end
    end else if (pushOk) begin
      if (count_q == 2'd0) slot0_d = data_i;
      else                 slot1_d = data_i;
      count_d = count_q + 2'd1;
    end else if (popOk) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot0_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/chacha_xor_stream.sv
// XORs buffered ChaCha keystream onto a valid/ready data stream, fetching
// blocks from the keystream unit with a single-outstanding request FSM.
module chacha_xor_stream
  import chacha_pkg::*;
#(
  parameter int DATA_W       = 128,
  parameter int RETRY_CYCLES = DEFAULT_RETRY_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  output logic                    ks_req_o,
  input  logic                    ks_valid_i,
  input  logic [CHACHA_BLK_W-1:0] ks_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [DATA_W-1:0]       s_data_i,
  input  logic [DATA_W/8-1:0]     s_keep_i,
  input  logic                    s_last_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [DATA_W-1:0]       m_data_o,
  output logic [DATA_W/8-1:0]     m_keep_o,
  output logic                    m_last_o,
  output logic                    ks_err_o
);

  localparam int BEATS  = CHACHA_BLK_W / DATA_W;
  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);

  req_state_e               state_q, state_d;
  logic                     ksReq_q, ksReq_d;
  logic [CNT_W-1:0]         retryCnt_q, retryCnt_d;
  logic                     stale_q, stale_d;
  logic                     ksErr_q, ksErr_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     mValid_q, mValid_d;
  logic [DATA_W-1:0]        mData_q, mData_d;
  logic [KEEP_W-1:0]        mKeep_q, mKeep_d;
  logic                     mLast_q, mLast_d;

  logic [CHACHA_BLK_W-1:0]      fifoHead;
  logic [BEATS-1:0][DATA_W-1:0] headWords;
  logic [DATA_W-1:0]            headWord;
  logic [DATA_W-1:0]            keepMask;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic [1:0]                   fifoCount;
  logic                         sReady;
  logic                         accept;
  logic                         clearNow;
  logic                         popNow;
  logic                         pushNow;

  chacha_ks_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clearNow),
    .push_i  (pushNow),
    .pop_i   (popNow),
    .data_i  (ks_data_i),
    .head_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign headWords = fifoHead;
  assign headWord  = headWords[idx_q];

  assign sReady   = !fifoEmpty && (!mValid_q || m_ready_i);
  assign accept   = s_valid_i && sReady;
  assign clearNow = flush_i || (accept && s_last_i);
  assign popNow   = accept && !clearNow && (idx_q == IDX_LAST);
  // A response landing together with a clear belongs to the old message.
  assign pushNow  = ks_valid_i && (state_q == R_WAIT) && !stale_q && !clearNow &&
                    ((fifoCount != 2'd2) || popNow);

  always_comb begin
    keepMask = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      keepMask[8*b +: 8] = {8{s_keep_i[b]}};
    end
  end

  // Request FSM: one request in flight, re-pulsed if the upstream core never answers.
  always_comb begin
    state_d    = state_q;
    ksReq_d    = 1'b0;
    retryCnt_d = retryCnt_q;
    stale_d    = stale_q;
    ksErr_d    = ksErr_q;
    case (state_q)
      R_IDLE: begin
        if (ks_valid_i) begin
          ksErr_d = 1'b1;
        end else if (!fifoFull) begin
          state_d    = R_WAIT;
          ksReq_d    = 1'b1;
          retryCnt_d = '0;
        end
      end
      R_WAIT: begin
        if (ks_valid_i) begin
          state_d = R_IDLE;
          stale_d = 1'b0;
        end else begin
          if (clearNow) stale_d = 1'b1;
          if (retryCnt_q == RETRY_LAST) begin
            ksReq_d    = 1'b1;
            retryCnt_d = '0;
          end else begin
            retryCnt_d = retryCnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Word index and output register; m_* only change on accept or handoff.
  always_comb begin
    idx_d    = idx_q;
    mValid_d = mValid_q;
    mData_d  = mData_q;
    mKeep_d  = mKeep_q;
    mLast_d  = mLast_q;
    if (clearNow || popNow) idx_d = '0;
    else if (accept)        idx_d = idx_q + IDX_W'(1);
    if (accept) begin
      mValid_d = 1'b1;
      mData_d  = (s_data_i ^ headWord) & keepMask;
      mKeep_d  = s_keep_i;
      mLast_d  = s_last_i;
    end else if (m_ready_i) begin
      mValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= R_IDLE;
      ksReq_q    <= 1'b0;
      retryCnt_q <= '0;
      stale_q    <= 1'b0;
      ksErr_q    <= 1'b0;
      idx_q      <= '0;
      mValid_q   <= 1'b0;
      mData_q    <= '0;
      mKeep_q    <= '0;
      mLast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ksReq_q    <= ksReq_d;
      retryCnt_q <= retryCnt_d;
      stale_q    <= stale_d;
      ksErr_q    <= ksErr_d;
      idx_q      <= idx_d;
      mValid_q   <= mValid_d;
      mData_q    <= mData_d;
      mKeep_q    <= mKeep_d;
      mLast_q    <= mLast_d;
    end
  end

  assign ks_req_o  = ksReq_q;
  assign s_ready_o = sReady;
  assign m_valid_o = mValid_q;
  assign m_data_o  = mData_q;
  assign m_keep_o  = mKeep_q;
  assign m_last_o  = mLast_q;
  assign ks_err_o  = ksErr_q;

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Directed bench for chacha_xor_stream: the bench plays the keystream unit
// and both stream endpoints.
module tb_chacha_xor_stream;

  localparam int DATA_W = 128;
  localparam int RETRY  = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic         ks_req_o;
  logic         ks_valid_i;
  logic [511:0] ks_data_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [127:0] s_data_i;
  logic [15:0]  s_keep_i;
  logic         s_last_i;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [127:0] m_data_o;
  logic [15:0]  m_keep_o;
  logic         m_last_o;
  logic         ks_err_o;

  int checks = 0;
  int errors = 0;

  chacha_xor_stream #(.DATA_W(DATA_W), .RETRY_CYCLES(RETRY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .ks_req_o   (ks_req_o),
    .ks_valid_i (ks_valid_i),
    .ks_data_i  (ks_data_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .s_keep_i   (s_keep_i),
    .s_last_i   (s_last_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_keep_o   (m_keep_o),
    .m_last_o   (m_last_o),
    .ks_err_o   (ks_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    int unsigned  cyc;
  } outRec_t;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [127:0] expData;
    logic [15:0]  expKeep;
    logic         expLast;
  } vec_t;

  int unsigned cyc = 0;
  int unsigned reqStamps[$];
  outRec_t     outQ[$];

  // Record every ks_req pulse and every output handoff with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ks_req_o) reqStamps.push_back(cyc);
    if (m_valid_o && m_ready_i) outQ.push_back('{m_data_o, m_keep_o, m_last_o, cyc});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [511:0] mkBlock(input logic [31:0] base);
    logic [511:0] blk;
    for (int w = 0; w < 4; w++) blk[w*128 +: 128] = {4{base + 32'(w)}};
    return blk;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [127:0] data, input logic [15:0] keep,
                               input logic last);
    int n;
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_keep_i  = keep;
    s_last_i  = last;
    #1;
    n = 0;
    while (!s_ready_o && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL s_ready timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic giveKs(input logic [511:0] blk);
    ks_valid_i = 1'b1;
    ks_data_i  = blk;
    tick();
    ks_valid_i = 1'b0;
  endtask

  task automatic waitReqs(input int target);
    int n;
    n = 0;
    while (reqStamps.size() < target && n < 200) begin
      tick();
      n++;
    end
    checkOutput("ks_req arrival count", 128'(reqStamps.size() >= target), 128'(1));
  endtask

  initial begin
    vec_t         vecs[3];
    logic [511:0] kA;
    int           base;
    int           ob;

    kA = {16{32'hA5A5A5A5}};
    vecs[0] = '{128'h0F0F0FFF_0F0F0FFF_0F0F0FFF_0F0F0FFF, 16'hFFFF, 1'b0,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'hFFFF, 1'b0};
    vecs[1] = '{128'h12345678_9ABCDEF0_00000000_FFFFFFFF, 16'hFFFF, 1'b0,
                128'hE2C4A679_6A4C2EF1_F0F0F001_0F0F0FFE, 16'hFFFF, 1'b0};
    vecs[2] = '{128'hDEADBEEF_DEADBEEF_01234567_89ABCDEF, 16'h00FF, 1'b1,
                128'h00000000_00000000_F1D3B565_795B3DED, 16'h00FF, 1'b1};

    rst_n      = 1'b0;
    flush_i    = 1'b0;
    ks_valid_i = 1'b0;
    ks_data_i  = '0;
    s_valid_i  = 1'b0;
    s_data_i   = '0;
    s_keep_i   = '0;
    s_last_i   = 1'b0;
    m_ready_i  = 1'b1;

    // Reset values and the first block
    repeat (3) tick();
    checkOutput("reset ks_req", 128'(ks_req_o), 128'(0));
    checkOutput("reset m_valid", 128'(m_valid_o), 128'(0));
    checkOutput("reset m_data", m_data_o, 128'h0);
    checkOutput("reset m_keep", 128'(m_keep_o), 128'(0));
    checkOutput("reset m_last", 128'(m_last_o), 128'(0));
    checkOutput("reset ks_err", 128'(ks_err_o), 128'(0));
    checkOutput("reset s_ready", 128'(s_ready_o), 128'(0));
    rst_n = 1'b1;
    base = reqStamps.size();
    waitReqs(base + 1);
    repeat (10) tick();
    giveKs(kA);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(128'h0, 16'hFFFF, 1'b0);
      checkOutput("t1 m_valid", 128'(m_valid_o), 128'(1));
      checkOutput("t1 m_data", m_data_o, {4{32'hA5A5A5A5}});
    end
    waitReqs(base + 2);
    checkOutput("t1 ks_err", 128'(ks_err_o), 128'(0));

    // Two primed blocks, eight back-to-back beats
    giveKs(mkBlock(32'h1000_0000));
    waitReqs(base + 3);
    giveKs(mkBlock(32'h1100_0000));
    repeat (2) tick();
    base = reqStamps.size();
    ob   = outQ.size();
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(128'h0, 16'hFFFF, 1'b0);
      end
      begin
        waitReqs(base + 1);
        giveKs(mkBlock(32'hF0F0_F000));
      end
    join
    repeat (6) tick();
    checkOutput("t2 extra ks_req", 128'(reqStamps.size() - base), 128'(2));
    checkOutput("t2 output count", 128'(outQ.size() - ob), 128'(8));
    if (outQ.size() - ob >= 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput("t2 m_data", outQ[ob+i].data,
                    (i < 4) ? {4{32'h1000_0000 + 32'(i)}} : {4{32'h1100_0000 + 32'(i-4)}});
        checkOutput("t2 consecutive", 128'(outQ[ob+i].cyc - outQ[ob].cyc), 128'(i));
      end
    end

    // Table vectors ending in a partial s_last beat; both slots must be dropped
    waitReqs(base + 2);
    giveKs(mkBlock(32'h3333_0000));
    base = reqStamps.size();
    for (int v = 0; v < 3; v++) begin
      applyStimulus(vecs[v].data, vecs[v].keep, vecs[v].last);
      checkOutput("t3 m_data", m_data_o, vecs[v].expData);
      checkOutput("t3 m_keep", 128'(m_keep_o), 128'(vecs[v].expKeep));
      checkOutput("t3 m_last", 128'(m_last_o), 128'(vecs[v].expLast));
    end
    checkOutput("t3 s_ready after clear", 128'(s_ready_o), 128'(0));
    waitReqs(base + 1);
    giveKs(mkBlock(32'h4444_0000));
    base = reqStamps.size();
    applyStimulus(128'h00000000_11111111_22222222_33333333, 16'hFFFF, 1'b0);
    checkOutput("t3 new block w0", m_data_o, 128'h44440000_55551111_66662222_77773333);

    // Unanswered request is re-pulsed after RETRY cycles
    waitReqs(base + 2);
    if (reqStamps.size() >= base + 2)
      checkOutput("t4 retry spacing", 128'(reqStamps[base+1] - reqStamps[base]), 128'(RETRY));
    giveKs(mkBlock(32'h5555_0000));
    base = reqStamps.size();
    repeat (70) tick();
    checkOutput("t4 no request when full", 128'(reqStamps.size()), 128'(base));
    for (int i = 1; i < 5; i++) begin
      applyStimulus(128'h0, 16'hFFFF, 1'b0);
      checkOutput("t4 m_data", m_data_o,
                  (i < 4) ? {4{32'h4444_0000 + 32'(i)}} : {4{32'h5555_0000}});
    end

    // Unsolicited keystream while idle
    waitReqs(base + 1);
    giveKs(mkBlock(32'h6666_0000));
    checkOutput("t5 ks_err before", 128'(ks_err_o), 128'(0));
    giveKs(kA);
    checkOutput("t5 ks_err set", 128'(ks_err_o), 128'(1));
    repeat (5) tick();
    checkOutput("t5 ks_err sticky", 128'(ks_err_o), 128'(1));

    // Flush with a request in flight; stale answer dropped; output stall
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 reset ks_err", 128'(ks_err_o), 128'(0));
    checkOutput("t6 reset m_valid", 128'(m_valid_o), 128'(0));
    tick();
    rst_n = 1'b1;
    base = reqStamps.size();
    waitReqs(base + 1);
    giveKs(mkBlock(32'h7777_0000));
    waitReqs(base + 2);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checkOutput("t6 s_ready after flush", 128'(s_ready_o), 128'(0));
    giveKs(kA);
    checkOutput("t6 stale ks_err", 128'(ks_err_o), 128'(0));
    checkOutput("t6 stale not pushed", 128'(s_ready_o), 128'(0));
    waitReqs(base + 3);
    giveKs(mkBlock(32'h8888_0000));
    m_ready_i = 1'b0;
    applyStimulus({4{32'hFFFFFFFF}}, 16'hFFFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t6 hold m_valid", 128'(m_valid_o), 128'(1));
      checkOutput("t6 hold m_data", m_data_o, {4{32'h7777FFFF}});
      tick();
    end
    checkOutput("t6 s_ready while stalled", 128'(s_ready_o), 128'(0));
    m_ready_i = 1'b1;
    tick();
    checkOutput("t6 m_valid drops", 128'(m_valid_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
